// File: rtl/slice_add_seq.sv
// Sequenced adder: one 3-bit slice per clock through a shared add stage,
// carry chained in a register, valid/ready handshake on operands and result.
module slice_add_seq #(
  parameter int unsigned SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*SLICES-1:0]   in_a,
  input  logic [3*SLICES-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*SLICES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
);

  localparam int unsigned W    = 3 * SLICES;
  localparam int unsigned IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_sum;
  logic [IDXW-1:0] r_idx;
  logic            r_carry, r_cout;
  logic [2:0]      w_a_sl, w_b_sl;
  logic [3:0]      w_t;

  // Slice mux over the latched operands, then the single 3-bit add stage.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int unsigned i = 0; i < SLICES; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_sl = r_a[3*i +: 3];
        w_b_sl = r_b[3*i +: 3];
      end
    end
    w_t = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {3'b000, r_carry};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)       w_next = ADD;
      ADD:     if (r_idx == LAST)  w_next = DONE;
      DONE:    if (out_ready)      w_next = IDLE;
      default:                     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
          end
        end
        ADD: begin
          for (int unsigned i = 0; i < SLICES; i++) begin
            if (r_idx == IDXW'(i)) r_sum[3*i +: 3] <= w_t[2:0];
          end
          r_carry <= w_t[3];
          if (r_idx == LAST) r_cout <= w_t[3];
          else               r_idx  <= r_idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ADD) || (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

endmodule

// File: tb/tb_slice_add_seq.sv
// Directed bench for slice_add_seq (SLICES=4 and SLICES=1) with a
// scoreboard filled on operand acceptance and drained on result handshake.
module tb_slice_add_seq;

  logic clk;
  logic rst_n;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_cout4, busy4;
  logic [11:0] in_a4, in_b4, out_sum4;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_cout1, busy1;
  logic [2:0]  in_a1, in_b1, out_sum1;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int acc4    = 0;
  int acc1    = 0;
  int acc_log4[$];
  logic [12:0] sb4[$];
  logic [3:0]  sb1[$];
  bit prev_ov4 = 1'b0;
  bit prev_ov1 = 1'b0;

  slice_add_seq #(.SLICES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
    .out_cout(out_cout4), .busy(busy4)
  );

  slice_add_seq #(.SLICES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Scoreboard side of the 4-slice instance.
  always @(negedge clk) begin
    logic [12:0] e;
    #1;
    if (rst_n) begin
      if (in_valid4 && in_ready4) begin
        sb4.push_back({1'b0, in_a4} + {1'b0, in_b4});
        acc4 = cyc;
        acc_log4.push_back(cyc);
      end
      if (out_valid4 && !prev_ov4) chk("latency4", cyc - acc4, 5);
      if (out_valid4 && out_ready4) begin
        chk("sb4_has_entry", (sb4.size() > 0), 1);
        if (sb4.size() > 0) begin
          e = sb4.pop_front();
          chk("sum4", out_sum4, e[11:0]);
          chk("cout4", out_cout4, e[12]);
        end
      end
    end
    prev_ov4 = out_valid4;
  end

  always @(negedge clk) begin
    logic [3:0] e;
    #1;
    if (rst_n) begin
      if (in_valid1 && in_ready1) begin
        sb1.push_back({1'b0, in_a1} + {1'b0, in_b1});
        acc1 = cyc;
      end
      if (out_valid1 && !prev_ov1) chk("latency1", cyc - acc1, 2);
      if (out_valid1 && out_ready1) begin
        chk("sb1_has_entry", (sb1.size() > 0), 1);
        if (sb1.size() > 0) begin
          e = sb1.pop_front();
          chk("sum1", out_sum1, e[2:0]);
          chk("cout1", out_cout1, e[3]);
        end
      end
    end
    prev_ov1 = out_valid1;
  end

  // Leaves in_valid asserted; returns at the negedge after the accepting edge.
  task automatic send4(input logic [11:0] a, input logic [11:0] b);
    bit ok = 1'b0;
    @(negedge clk);
    in_a4 = a; in_b4 = b; in_valid4 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (in_ready4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept4", ok, 1);
    @(negedge clk);
  endtask

  task automatic send1(input logic [2:0] a, input logic [2:0] b);
    bit ok = 1'b0;
    @(negedge clk);
    in_a1 = a; in_b1 = b; in_valid1 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (in_ready1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept1", ok, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle4();
    int bad = 0;
    bit done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (busy4 && in_ready4) bad++;
      if (!busy4) begin done = 1'b1; break; end
    end
    chk("idle4_reached", done, 1);
    chk("ready_low_busy4", bad, 0);
    chk("ready_after_hs4", in_ready4, 1);
  endtask

  task automatic wait_idle1();
    bit done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (!busy1) begin done = 1'b1; break; end
    end
    chk("idle1_reached", done, 1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready4", in_ready4, 0);
    chk("rst_out_valid4", out_valid4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_sum4", out_sum4, 0);
    chk("rst_cout4", out_cout4, 0);
    chk("rst_in_ready1", in_ready1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_post_rst4", in_ready4, 1);

    send4(12'd2, 12'd2);
    in_valid4 = 1'b0;
    wait_idle4();

    // Back-to-back with out_ready tied high: initiation interval.
    send4(12'd3, 12'd7);
    send4(12'd5, 12'd1);
    in_valid4 = 1'b0;
    wait_idle4();
    chk("ii4", acc_log4[acc_log4.size()-1] - acc_log4[acc_log4.size()-2], 6);

    send4(12'hFFF, 12'h001);
    in_valid4 = 1'b0;
    wait_idle4();
    send4(12'hFFF, 12'hFFF);
    in_valid4 = 1'b0;
    wait_idle4();

    // Backpressure: DONE must hold and ignore a new request.
    out_ready4 = 1'b0;
    send4(12'h123, 12'h456);
    in_valid4 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (out_valid4) begin seen = 1'b1; break; end
    end
    chk("bp_valid_seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin in_a4 = 12'd1; in_b4 = 12'd0; in_valid4 = 1'b1; end
      #1;
      chk("bp_sum", out_sum4, 12'h579);
      chk("bp_cout", out_cout4, 0);
      chk("bp_valid", out_valid4, 1);
      chk("bp_in_ready", in_ready4, 0);
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_valid", out_valid4, 0);
    chk("bp_release_ready", in_ready4, 1);

    // Reset after two ADD edges discards the operation.
    send4(12'h7FF, 12'h001);
    in_valid4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_valid", out_valid4, 0);
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_sum", out_sum4, 0);
    chk("mid_rst_cout", out_cout4, 0);
    chk("mid_rst_ready", in_ready4, 0);
    sb4.delete();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid4) seen = 1'b1;
    end
    chk("mid_rst_no_valid", seen, 0);
    send4(12'h010, 12'h020);
    in_valid4 = 1'b0;
    wait_idle4();

    send1(3'd5, 3'd1);
    in_valid1 = 1'b0;
    wait_idle1();
    send1(3'd7, 3'd7);
    in_valid1 = 1'b0;
    wait_idle1();

    chk("sb4_drained", sb4.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slice_add_seq.md
# slice_add_seq

Sequenced multi-slice adder controller: accepts two operands of SLICES×3 bits and adds them by stepping one 3-bit slice per clock through a single 3-bit add stage, chaining the carry between slices in a register. It sits between a requester and the result consumer and owns all sequencing, carry chaining and result buffering. It trades latency for area against a full-width adder. Operands and results use a valid/ready handshake on each side.

## Interface

- SLICES, default 4: number of 3-bit slices; operand width W = 3×SLICES (default 12); legal range SLICES ≥ 1.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on clk rising edge.
- in_valid  in  1  requester presents operands.
- in_ready  out  1  block can accept operands; equals (state == IDLE) and rst_n high.
- in_a  in  W  operand A; bits [3i+2:3i] form slice i, with slice 0 as the LSBs.
- in_b  in  W  operand B; same slicing as in_a.
- out_valid  out  1  result available; high only in state DONE.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  registered sum, modulo 2^W.
- out_cout  out  1  registered carry out of the top slice.
- busy  out  1  high in ADD or DONE.

## Operation

- States: IDLE, ADD, DONE. Internal registers: a_q, b_q (W), idx (width ceil(log2(SLICES)), minimum 1), carry (1), plus out_sum and out_cout.
- IDLE: in_ready = 1. When in_valid && in_ready at an edge:
  - latch in_a/in_b into a_q/b_q;
  - set idx = 0, carry = 0, out_sum = 0, out_cout = 0;
  - go to ADD.
- ADD: each cycle compute the 4-bit value t = a_q slice idx + b_q slice idx + carry, zero-extended.
  - out_sum slice idx ← t[2:0]; carry ← t[3].
  - If idx == SLICES−1: out_cout ← t[3]; go to DONE.
  - Otherwise idx ← idx + 1.
  - in_ready = 0 throughout; in_valid and operand inputs are ignored.
- DONE: out_valid = 1. out_sum and out_cout are held stable until out_ready is sampled high; then go to IDLE.
- in_ready is never high in DONE, so a new operand cannot be accepted in the same cycle as the result handshake.
- in_a/in_b may change freely after acceptance; only the latched copies are used.
- Upper out_sum slices read 0 until they are written; consumers must not sample out_sum while out_valid = 0.
- SLICES = 1: ADD lasts one cycle; idx stays 0.

## Timing

- Reset values (after an edge with rst_n = 0): state = IDLE, out_valid = 0, busy = 0, out_sum = 0, out_cout = 0, idx = 0, carry = 0.
- in_ready = 0 while rst_n is low, and 1 from the first cycle after reset is released.
- Latency: operands accepted at edge E. ADD occupies edges E+1 through E+SLICES. out_valid rises after edge E+SLICES (4 cycles for the default).
- Minimum initiation interval is SLICES+2 cycles: accept, SLICES add cycles, DONE with out_ready high, then IDLE before the next accept.
- Backpressure: with out_ready low, DONE holds indefinitely and all outputs stay constant.
- Reset mid-operation (in ADD or DONE): the operation is discarded. out_valid never asserts for it, and all registers take their reset values.
- Carry: no overflow flag beyond out_cout. out_sum plus out_cout×2^W equals in_a + in_b exactly.

## Test plan

- SLICES=4. Accept in_a=2, in_b=2 at edge E → out_valid after edge E+4; out_sum=4, out_cout=0. in_ready is low from E+1 until the cycle after the handshake.
- SLICES=4. in_a=3, in_b=7 → out_sum=10, out_cout=0. Then in_a=5, in_b=1 back-to-back → out_sum=6. Measured initiation interval = 6 cycles with out_ready tied high.
- SLICES=4, full carry ripple:
  - in_a=0xFFF, in_b=0x001 → out_sum=0x000, out_cout=1.
  - in_a=0xFFF, in_b=0xFFF → out_sum=0xFFE, out_cout=1.
- Backpressure, SLICES=4, in_a=0x123, in_b=0x456:
  - hold out_ready=0 for 5 cycles in DONE → out_sum=0x579 and out_valid=1 stay stable; in_ready=0;
  - a new in_valid with in_a=1 during this window is not accepted;
  - out_ready=1 → IDLE on the next edge.
- Reset mid-ADD: rst_n=0 for one edge after 2 ADD cycles of 0x7FF+0x001 → out_valid stays 0, all outputs reset. The next op 0x010+0x020 returns 0x030.
- SLICES=1:
  - 5+1 → out_sum=6, out_cout=0, out_valid one cycle after accept;
  - 7+7 → out_sum=6, out_cout=1.
